// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pkg
//  Brief    : Shared encodings for the multi-cycle main control FSM:
//             state codes, opcode/Funct values, ALU control words,
//             operand/PC select codes and the opcode classifier.
//  Revision : 1.0  initial release
// ============================================================================
package ctrl_pkg;

  // FSM states; the numeric codes are visible on the State debug port
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  // Instruction class captured in DECODE and carried through the instruction
  typedef enum logic [2:0] {
    OPC_R    = 3'd0,
    OPC_ADDI = 3'd1,
    OPC_LW   = 3'd2,
    OPC_SW   = 3'd3,
    OPC_BEQ  = 3'd4,
    OPC_J    = 3'd5,
    OPC_ILL  = 3'd6
  } op_class_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_SLT = 3'b010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Map a raw opcode onto its instruction class (undefined opcodes -> OPC_ILL)
  function automatic op_class_t classify_opcode(input logic [3:0] opcode);
    op_class_t cls;
    case (opcode)
      OP_RTYPE: cls = OPC_R;
      OP_ADDI:  cls = OPC_ADDI;
      OP_LW:    cls = OPC_LW;
      OP_SW:    cls = OPC_SW;
      OP_BEQ:   cls = OPC_BEQ;
      OP_J:     cls = OPC_J;
      default:  cls = OPC_ILL;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Brief    : Combinational map from (instruction class, Funct) to the ALU
//             control word, plus a flag for undefined opcode/Funct values.
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_decode
  import ctrl_pkg::*;
(
  input  op_class_t   i_op_class,
  input  logic [2:0]  i_funct,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_illegal
);

  // Only R-type selects the ALU function from Funct; everything else adds
  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    case (i_op_class)
      OPC_R: begin
        case (i_funct)
          FN_ADD:  o_alu_ctrl = ALU_ADD;
          FN_SUB:  o_alu_ctrl = ALU_SUB;
          FN_SLT:  o_alu_ctrl = ALU_SLT;
          default: o_illegal  = 1'b1;
        endcase
      end
      OPC_ILL: o_illegal = 1'b1;
      default: o_illegal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Multi-cycle main control FSM (fetch/decode/exec/mem/wb plus
//             branch and jump) for the 16-bit datapath. Drives ALU control,
//             operand and PC selects, memory strobes and write enables.
//  Options  : CTRL_MEM_TIMEOUT_EN - abandon a memory wait after
//             TIMEOUT_CYCLES consecutive MemReady-low cycles and raise the
//             sticky Timeout flag. Undefined: wait forever, Timeout = 0.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  Opcode,
  input  logic [2:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [3:0]  ALU_Ctrl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemToReg,
  output logic [1:0]  PCSrc,
  output logic [2:0]  State,
  output logic        IllegalOp,
  output logic        Timeout
);

  state_t     r_state;
  state_t     w_next_state;
  op_class_t  r_op_class;
  logic [2:0] r_funct;
  logic       r_illegal;

  op_class_t  w_live_class;
  op_class_t  w_dec_class;
  logic [2:0] w_dec_funct;
  logic [3:0] w_alu_fn;
  logic       w_fn_illegal;
  logic       w_timeout_hit;

  // In DECODE the live IR fields are judged; afterwards the latched copy is used
  assign w_live_class = classify_opcode(Opcode);
  assign w_dec_class  = (r_state == S_DECODE) ? w_live_class : r_op_class;
  assign w_dec_funct  = (r_state == S_DECODE) ? Funct : r_funct;

  alu_op_decode u_alu_op_decode (
    .i_op_class (w_dec_class),
    .i_funct    (w_dec_funct),
    .o_alu_ctrl (w_alu_fn),
    .o_illegal  (w_fn_illegal)
  );

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_timeout;
  logic       w_waiting;

  assign w_waiting     = ((r_state == S_FETCH) || (r_state == S_MEM)) && !MemReady;
  assign w_timeout_hit = w_waiting && (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled memory cycles; restart on progress or state change
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= 8'd0;
    end else if (!w_waiting || w_timeout_hit || (w_next_state != r_state)) begin
      r_wait_cnt <= 8'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_hit) begin
      r_timeout <= 1'b1;
    end
  end

  assign Timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign Timeout       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the instruction class and Funct so later IR changes are ignored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op_class <= OPC_R;
      r_funct    <= FN_ADD;
    end else if (r_state == S_DECODE) begin
      r_op_class <= w_live_class;
      r_funct    <= Funct;
    end
  end

  // Sticky illegal-instruction flag, set when DECODE rejects the instruction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_DECODE) && w_fn_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign IllegalOp = r_illegal;
  assign State     = r_state;

  // Next-state and control outputs; reset forces every strobe low
  always_comb begin
    w_next_state = r_state;
    ALU_Ctrl     = ALU_ADD;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REGB;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    MemToReg     = 1'b0;
    PCSrc        = PCSRC_ALU;

    if (rst_i) begin
      w_next_state = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_ONE;
          if (MemReady) begin
            IRWrite      = 1'b1;
            PCWrite      = 1'b1;
            w_next_state = S_DECODE;
          end else begin
            w_next_state = S_FETCH;
          end
        end

        S_DECODE: begin
          ALUSrcB = SRCB_BOFS;
          if (w_fn_illegal) begin
            w_next_state = S_FETCH;
          end else begin
            case (w_live_class)
              OPC_BEQ: w_next_state = S_BRANCH;
              OPC_J:   w_next_state = S_JUMP;
              default: w_next_state = S_EXEC;
            endcase
          end
        end

        S_EXEC: begin
          ALUSrcA  = 1'b1;
          ALU_Ctrl = w_alu_fn;
          ALUSrcB  = (r_op_class == OPC_R) ? SRCB_REGB : SRCB_IMM;
          if ((r_op_class == OPC_LW) || (r_op_class == OPC_SW)) begin
            w_next_state = S_MEM;
          end else begin
            w_next_state = S_WB;
          end
        end

        S_MEM: begin
          if (w_timeout_hit) begin
            // Pending access is dropped: no strobe on the abandoning cycle
            w_next_state = S_FETCH;
          end else begin
            MemRead  = (r_op_class == OPC_LW);
            MemWrite = (r_op_class == OPC_SW);
            if (MemReady) begin
              w_next_state = (r_op_class == OPC_LW) ? S_WB : S_FETCH;
            end
          end
        end

        S_WB: begin
          RegWrite     = 1'b1;
          RegDst       = (r_op_class == OPC_R);
          MemToReg     = (r_op_class == OPC_LW);
          w_next_state = S_FETCH;
        end

        S_BRANCH: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_REGB;
          ALU_Ctrl     = ALU_SUB;
          PCSrc        = PCSRC_ALUOUT;
          PCWrite      = Zero;
          w_next_state = S_FETCH;
        end

        S_JUMP: begin
          PCWrite      = 1'b1;
          PCSrc        = PCSRC_JUMP;
          w_next_state = S_FETCH;
        end

        default: begin
          w_next_state = S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
